// File: rtl/ltica_pkg.sv
// Shared constants and types for the jb output path.
// Holds the drive-stage state encoding and the counter width helper.
package ltica_pkg;

    localparam int DEF_N_CH       = 6;
    localparam int DEF_DEAD_CYC   = 64;
    localparam int DEF_MAX_ACTIVE = 2;

    typedef enum logic [1:0] {
        IDLE,
        DEAD,
        RUN,
        FAULT
    } state_e;

    // A one-cycle dead time still needs a 1-bit counter.
    function automatic int DCNT_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ch_popcount.sv
// Combinational set-bit count of a channel pattern.
// Shared by the dead-time gate and the phase table checker.
module ch_popcount #(
    parameter int N = 6,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0] bits,
    output logic [W-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + W'(bits[i]);
        end
    end

endmodule

// File: rtl/deadtime_gate.sv
// Gates the modulator pulse onto the selected jb pattern with a
// break-before-make dead time and a sticky illegal-pattern fault.
module deadtime_gate
    import ltica_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int DEAD_CYC   = DEF_DEAD_CYC,
    parameter int MAX_ACTIVE = DEF_MAX_ACTIVE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            pulse,
    input  logic [N_CH-1:0] arr,
    output logic [N_CH-1:0] sparr,
    output logic            busy,
    output logic            fault
);

    localparam int DW = DCNT_W(DEAD_CYC);
    localparam int CW = $clog2(N_CH + 1);
    localparam logic [DW-1:0] DLOAD = DW'(DEAD_CYC - 1);

    state_e          state, nstate;
    logic [N_CH-1:0] pat, pat_n;
    logic [DW-1:0]   dcnt, dcnt_n;
    logic [N_CH-1:0] sparr_n;
    logic            busy_n, fault_n;
    logic [CW-1:0]   ones;
    logic            illegal, change;

    ch_popcount #(
        .N (N_CH),
        .W (CW)
    ) u_pc (
        .bits (arr),
        .cnt  (ones)
    );

    assign illegal = int'(ones) > MAX_ACTIVE;
    assign change  = arr != pat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pat   <= '0;
            dcnt  <= '0;
            sparr <= '0;
            busy  <= 1'b0;
            fault <= 1'b0;
        end else begin
            state <= nstate;
            pat   <= pat_n;
            dcnt  <= dcnt_n;
            sparr <= sparr_n;
            busy  <= busy_n;
            fault <= fault_n;
        end
    end

    always_comb begin
        nstate = state;
        pat_n  = pat;
        dcnt_n = dcnt;
        if (!en) begin
            nstate = IDLE;
        end else if (state == FAULT) begin
            nstate = FAULT;
        end else if (illegal) begin
            nstate = FAULT;
        end else begin
            unique case (state)
                IDLE: begin
                    pat_n  = arr;
                    dcnt_n = DLOAD;
                    nstate = DEAD;
                end
                DEAD: begin
                    if (change) begin
                        pat_n  = arr;
                        dcnt_n = DLOAD;
                    end else if (dcnt == '0) begin
                        nstate = RUN;
                    end else begin
                        dcnt_n = dcnt - 1'b1;
                    end
                end
                RUN: begin
                    if (change) begin
                        pat_n  = arr;
                        dcnt_n = DLOAD;
                        nstate = DEAD;
                    end
                end
                default: nstate = state;
            endcase
        end
    end

    // Pins drive only while RUN is both the current and next state.
    always_comb begin
        sparr_n = '0;
        busy_n  = nstate == DEAD;
        fault_n = nstate == FAULT;
        if (state == RUN && nstate == RUN) begin
            sparr_n = pat & {N_CH{pulse}};
        end
    end

endmodule

// File: tb/tb_deadtime_gate.sv
// Directed bench for deadtime_gate with a timestamp-based reference
// model checked every cycle plus hand-computed timing expectations.
module tb_deadtime_gate;

    localparam int N = 6;
    localparam int D = 64;
    localparam int M = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         pulse = 1'b0;
    logic [N-1:0] arr = '0;
    logic [N-1:0] sparr;
    logic         busy;
    logic         fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    deadtime_gate #(
        .N_CH       (N),
        .DEAD_CYC   (D),
        .MAX_ACTIVE (M)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .pulse (pulse),
        .arr   (arr),
        .sparr (sparr),
        .busy  (busy),
        .fault (fault)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: a pattern accepted at edge n may first drive at edge n+D+1.
    logic         m_on, m_flt;
    logic [N-1:0] m_pat;
    int           m_n, m_run;
    logic [N-1:0] e_sparr;
    logic         e_busy, e_fault;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_on = 0; m_flt = 0; m_pat = '0; m_n = 0; m_run = 0;
            e_sparr = '0; e_busy = 0; e_fault = 0;
        end else begin
            m_n++;
            e_sparr = '0; e_busy = 0; e_fault = 0;
            if (!en) begin
                m_on = 0; m_flt = 0;
            end else if (m_flt) begin
                e_fault = 1;
            end else if ($countones(arr) > M) begin
                m_flt = 1; m_on = 0; e_fault = 1;
            end else if (!m_on || arr != m_pat) begin
                m_on = 1; m_pat = arr; m_run = m_n + D; e_busy = 1;
            end else begin
                e_busy = m_n < m_run;
                if (m_n > m_run) e_sparr = m_pat & {N{pulse}};
            end
        end
    end

    logic [N-1:0] prev_s = '0;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("model_sparr", int'(sparr), int'(e_sparr));
            chk("model_busy", int'(busy), int'(e_busy));
            chk("model_fault", int'(fault), int'(e_fault));
            if (prev_s != '0 && sparr != '0)
                chk("adjacent_patterns", int'(sparr), int'(prev_s));
            prev_s = sparr;
        end else begin
            prev_s = '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic measure(input int maxk, output int first,
                           output int nb, output int val);
        first = 0; nb = 0; val = 0;
        for (int k = 1; k <= maxk; k++) begin
            tick();
            if (busy) nb++;
            if (sparr != '0 && first == 0) begin
                first = k;
                val = int'(sparr);
            end
        end
    endtask

    int first, nb, val;

    initial begin
        repeat (3) tick();
        chk("reset_sparr", int'(sparr), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_fault", int'(fault), 0);
        rst = 0;
        tick();

        en = 1; arr = 6'b000011; pulse = 1;
        measure(70, first, nb, val);
        chk("enable_busy_len", nb, 64);
        chk("enable_first_drive", first, 66);
        chk("enable_drive_val", val, 3);

        for (int k = 0; k < 8; k++) begin
            pulse = k[0];
            tick();
            chk("pulse_lag", int'(sparr), k[0] ? 3 : 0);
        end
        pulse = 1;
        tick();

        arr = 6'b000110;
        measure(80, first, nb, val);
        chk("change_first_drive", first, 66);
        chk("change_drive_val", val, 6);

        arr = 6'b011000;
        first = 0; val = 0;
        for (int k = 1; k <= 110; k++) begin
            if (k == 31) arr = 6'b100001;
            tick();
            if (sparr != '0 && first == 0) begin
                first = k;
                val = int'(sparr);
            end
        end
        chk("restart_first_drive", first, 96);
        chk("restart_drive_val", val, 33);

        arr = 6'b000111;
        tick();
        chk("illegal_fault", int'(fault), 1);
        chk("illegal_sparr", int'(sparr), 0);
        repeat (5) tick();
        chk("fault_sticky", int'(fault), 1);
        arr = 6'b000011;
        tick();
        chk("fault_sticky_legal", int'(fault), 1);
        en = 0;
        tick();
        chk("fault_cleared", int'(fault), 0);
        chk("disable_sparr", int'(sparr), 0);
        en = 1;
        measure(70, first, nb, val);
        chk("reenable_busy_len", nb, 64);
        chk("reenable_first_drive", first, 66);

        @(posedge clk);
        #3 rst = 1;
        #1;
        chk("rst_async_sparr", int'(sparr), 0);
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_fault", int'(fault), 0);
        tick();
        rst = 0;
        measure(70, first, nb, val);
        chk("post_rst_first_drive", first, 66);
        chk("post_rst_drive_val", val, 3);

        arr = 6'b000000;
        measure(70, first, nb, val);
        chk("zero_pattern_no_drive", first, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
